// File: rtl/agc_loop_controller.sv
// Closed-loop AGC gain controller: averages a 2^LOG2_WIN magnitude window, steps gain toward target.
// Latency: new gain two cycles after the last window sample; no backpressure, samples in UPDATE are dropped.
module agc_loop_controller #(
  parameter int unsigned LOG2_WIN     = 6,
  parameter int unsigned MU_SHIFT     = 4,
  parameter logic [15:0] GAIN_INIT    = 16'h0100,
  parameter logic [15:0] GAIN_MIN     = 16'h0010,
  parameter logic [15:0] GAIN_MAX     = 16'h7F00,
  parameter logic [15:0] LOCK_TOL     = 16'h0010,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] target,
  input  logic        mag_valid,
  input  logic [15:0] magnitude,
  output logic [15:0] gain,
  output logic        gain_update,
  output logic        locked,
  output logic        busy
);

  localparam int unsigned ACC_W = 16 + LOG2_WIN;
  localparam int unsigned LCK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [15:0]         gain_q, gain_d;
  logic                gain_update_q, gain_update_d;
  logic                locked_q, locked_d;

  logic [15:0]         avg;
  logic signed [16:0]  err;
  logic signed [16:0]  step;
  logic signed [16:0]  err_abs;
  logic signed [17:0]  sum;
  logic [15:0]         gain_new;
  logic                in_tol;

  assign avg     = acc_q[ACC_W-1:LOG2_WIN];
  assign err     = $signed({1'b0, target}) - $signed({1'b0, avg});
  assign step    = err >>> MU_SHIFT;
  assign sum     = $signed({2'b00, gain_q}) + $signed({step[16], step});
  assign err_abs = err[16] ? -err : err;
  assign in_tol  = (err_abs <= $signed({1'b0, LOCK_TOL}));

  // Sum is 18-bit signed so a large negative step cannot wrap past GAIN_MIN.
  always_comb begin
    gain_new = sum[15:0];
    if (sum < $signed({2'b00, GAIN_MIN})) begin
      gain_new = GAIN_MIN;
    end else if (sum > $signed({2'b00, GAIN_MAX})) begin
      gain_new = GAIN_MAX;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    lock_cnt_d    = lock_cnt_q;
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    locked_d      = locked_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!enable) begin
          state_d    = S_IDLE;
          acc_d      = '0;
          cnt_d      = '0;
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end else if (mag_valid) begin
          acc_d = acc_q + ACC_W'(magnitude);
          cnt_d = cnt_q + LOG2_WIN'(1);
          if (cnt_q == '1) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        acc_d         = '0;
        cnt_d         = '0;
        gain_d        = gain_new;
        gain_update_d = 1'b1;
        if (!in_tol) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_MAX) begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
        locked_d = (lock_cnt_d == LOCK_MAX);
        state_d  = enable ? S_ACCUM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      lock_cnt_q    <= '0;
      gain_q        <= GAIN_INIT;
      gain_update_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      locked_q      <= locked_d;
    end
  end

  assign gain        = gain_q;
  assign gain_update = gain_update_q;
  assign locked      = locked_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_agc_loop_controller.sv
// Scoreboarded bench for agc_loop_controller: stimulus queues expected gain/lock/cycle, monitor checks on gain_update.
module tb_agc_loop_controller;

  logic        clk;
  logic        rst_n;
  logic        enable, enable_b;
  logic [15:0] target;
  logic        mag_valid;
  logic [15:0] magnitude;

  logic [15:0] gain_a, gain_b;
  logic        gain_update_a, gain_update_b;
  logic        locked_a, locked_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] gain;
    logic        locked;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  agc_loop_controller dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target(target),
    .mag_valid(mag_valid), .magnitude(magnitude),
    .gain(gain_a), .gain_update(gain_update_a), .locked(locked_a), .busy(busy_a)
  );

  agc_loop_controller #(.GAIN_MAX(16'h0108)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .target(target),
    .mag_valid(mag_valid), .magnitude(magnitude),
    .gain(gain_b), .gain_update(gain_update_b), .locked(locked_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mag_valid = 1'b0;
    end
  endtask

  // Gap cycles precede each sample so the cycle after the task is the UPDATE cycle.
  task automatic send(input int n, input logic [15:0] m, input int gap,
                      input bit push_a, input bit push_b,
                      input logic [15:0] eg, input logic el);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        mag_valid = 1'b0;
      end
      @(posedge clk); #1;
      mag_valid = 1'b1;
      magnitude = m;
      if (i == n - 1) begin
        if (push_a) qa.push_back('{gain: eg, locked: el, cyc: cyc + 2});
        if (push_b) qb.push_back('{gain: eg, locked: el, cyc: cyc + 2});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gain_update_a) begin
        if (qa.size() == 0) begin
          chk("A_unexpected_update", {31'd0, gain_update_a}, 32'd0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("A_gain", {16'd0, gain_a}, {16'd0, e.gain});
          chk("A_locked", {31'd0, locked_a}, {31'd0, e.locked});
          chk("A_latency", cyc, e.cyc);
        end
      end
      if (gain_update_b) begin
        if (qb.size() == 0) begin
          chk("B_unexpected_update", {31'd0, gain_update_b}, 32'd0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("B_gain", {16'd0, gain_b}, {16'd0, e.gain});
          chk("B_locked", {31'd0, locked_b}, {31'd0, e.locked});
          chk("B_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; enable_b = 1'b0;
    target = 16'h0; mag_valid = 1'b0; magnitude = 16'h0;

    // Reset held with random inputs
    repeat (5) begin
      @(posedge clk); #1;
      enable    = 1'($urandom);
      enable_b  = 1'($urandom);
      mag_valid = 1'($urandom);
      target    = 16'($urandom);
      magnitude = 16'($urandom);
    end
    chk("rst_gain", {16'd0, gain_a}, 32'h0100);
    chk("rst_gain_update", {31'd0, gain_update_a}, 32'd0);
    chk("rst_locked", {31'd0, locked_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    enable = 1'b0; enable_b = 1'b0; mag_valid = 1'b0;
    #3 rst_n = 1'b1;

    // Nominal step
    enable = 1'b1; target = 16'h0200;
    idle(2);
    send(64, 16'h0100, 1, 1, 0, 16'h0110, 1'b0);
    idle(4);

    // Clamp low
    target = 16'h0000;
    send(64, 16'h4000, 1, 1, 0, 16'h0010, 1'b0);
    idle(4);

    // Clamp high on the GAIN_MAX=0x0108 instance while A is parked
    enable = 1'b0; enable_b = 1'b1; target = 16'h0200;
    idle(2);
    send(64, 16'h0100, 1, 0, 1, 16'h0108, 1'b0);
    idle(4);
    enable_b = 1'b0;
    idle(2);

    // Asynchronous reset mid-ACCUM
    enable = 1'b1;
    idle(2);
    send(10, 16'h4000, 1, 0, 0, 16'h0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0; mag_valid = 1'b0;
    #1;
    chk("arst_gain", {16'd0, gain_a}, 32'h0100);
    chk("arst_busy", {31'd0, busy_a}, 32'd0);
    chk("arst_locked", {31'd0, locked_a}, 32'd0);
    chk("arst_gain_update", {31'd0, gain_update_a}, 32'd0);
    #10 rst_n = 1'b1;
    idle(2);

    // Lock acquisition over four windows, lost on the fifth
    target = 16'h0100;
    send(64, 16'h0108, 1, 1, 0, 16'h00FF, 1'b0); idle(3);
    send(64, 16'h0108, 1, 1, 0, 16'h00FE, 1'b0); idle(3);
    send(64, 16'h0108, 1, 1, 0, 16'h00FD, 1'b0); idle(3);
    send(64, 16'h0108, 1, 1, 0, 16'h00FC, 1'b1); idle(3);
    send(64, 16'h0200, 1, 1, 0, 16'h00EC, 1'b0); idle(4);

    // Abort a partial window, then require a full fresh window
    target = 16'h0200;
    send(30, 16'h4000, 1, 0, 0, 16'h0, 1'b0);
    @(posedge clk); #1;
    mag_valid = 1'b0; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_gain", {16'd0, gain_a}, 32'h00EC);
    enable = 1'b1;
    idle(2);
    send(63, 16'h0100, 1, 0, 0, 16'h0, 1'b0);
    idle(5);
    chk("abort_63_gain", {16'd0, gain_a}, 32'h00EC);
    send(1, 16'h0100, 1, 1, 0, 16'h00FC, 1'b0);
    idle(4);

    // Gapped valid with a dropped sample in the UPDATE cycle
    send(64, 16'h0100, 3, 1, 0, 16'h010C, 1'b0);
    @(posedge clk); #1;
    mag_valid = 1'b1; magnitude = 16'hFFFF;
    idle(2);
    send(64, 16'h0100, 3, 1, 0, 16'h011C, 1'b0);
    idle(6);

    chk("A_pending", qa.size(), 32'd0);
    chk("B_pending", qb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agc_loop_controller.md
Name: agc_loop_controller

Overview:
- Closed-loop gain controller for the AGC path.
- Consumes the Q8.8 magnitude stream from the magnitude approximation stage and averages it over a fixed power-of-two window.
- Compares the average against a programmable target and updates a Q8.8 gain word with a shift-scaled first-order step, clamped to limits.
- Feeds the gain multiplier ahead of the magnitude stage and reports a lock flag.

Parameters:
- LOG2_WIN, 6: window length is 2^LOG2_WIN accepted magnitudes (64).
- MU_SHIFT, 4: loop step is error arithmetically right-shifted by MU_SHIFT.
- GAIN_INIT, 16'h0100: gain after reset (1.0 Q8.8).
- GAIN_MIN, 16'h0010: lower gain clamp (unsigned Q8.8).
- GAIN_MAX, 16'h7F00: upper gain clamp (unsigned Q8.8).
- LOCK_TOL, 16'h0010: lock tolerance on |error|.
- LOCK_WINDOWS, 4: consecutive in-tolerance windows required to assert locked.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  loop run; 0 parks the loop in IDLE
- target  in  16  desired average magnitude, unsigned Q8.8, sampled in UPDATE
- mag_valid  in  1  magnitude qualifier
- magnitude  in  16  magnitude sample, interpreted as unsigned Q8.8
- gain  out  16  current gain, unsigned Q8.8, registered
- gain_update  out  1  one-cycle pulse when gain is rewritten
- locked  out  1  loop converged
- busy  out  1  high in ACCUM or UPDATE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gain=GAIN_INIT, gain_update=0, locked=0, busy=0.
  - accumulator, sample counter and lock counter are 0.
- FSM states: IDLE, ACCUM, UPDATE.
- IDLE:
  - acc and count are cleared.
  - enable=1 moves to ACCUM on the next edge.
  - mag_valid is ignored.
- ACCUM, per cycle with mag_valid=1:
  - acc += magnitude, where acc is unsigned, 16+LOG2_WIN bits, and cannot overflow.
  - count += 1.
  - When the accepted sample is number 2^LOG2_WIN, the next state is UPDATE.
- ACCUM, with enable=0: next state is IDLE; the partial window is discarded, gain holds, locked clears and lock counter clears.
- UPDATE (exactly one cycle):
  - avg = acc >> LOG2_WIN (16 bits).
  - err = target − avg, 17-bit signed.
  - step = err >>> MU_SHIFT (arithmetic, floor).
  - sum = gain + step, evaluated at 18-bit signed.
  - New gain = GAIN_MIN if sum < GAIN_MIN, GAIN_MAX if sum > GAIN_MAX, else sum.
  - gain and gain_update=1 are registered on this edge.
  - Next state is ACCUM if enable=1, else IDLE.
  - The update always completes even if enable falls during UPDATE.
- mag_valid during UPDATE is dropped and not counted in either window.
- Latency: the final window sample is accepted on edge k; UPDATE occupies cycle k+1; new gain and gain_update are visible in cycle k+2. gain_update is low in all other cycles.
- Lock, evaluated in UPDATE:
  - If |err| ≤ LOCK_TOL, lock_cnt increments, saturating at LOCK_WINDOWS; otherwise lock_cnt=0.
  - locked = (lock_cnt == LOCK_WINDOWS), registered alongside gain.
  - Gain continues updating while locked.
- target changes mid-window affect only the UPDATE in which they are sampled.
- Reset asserted mid-operation returns all state to reset values immediately; no partial update is emitted.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> gain=0x0100, gain_update=0, locked=0, busy=0; also assert rst_n mid-ACCUM -> same values asynchronously.
2. Nominal step: enable=1, target=0x0200, 64 valid samples of 0x0100 back-to-back -> one gain_update pulse 2 cycles after the 64th sample, gain=0x0110.
3. Clamp low: target=0x0000, 64 samples of 0x4000 -> step=−0x0400, gain=0x0010 (GAIN_MIN); with GAIN_MAX=0x0108 override, target=0x0200, samples 0x0100 -> gain=0x0108.
4. Lock: target=0x0100, samples 0x0108 for 4 windows -> err=−8 each window, gain steps by −1 per window, locked rises with the 4th gain_update; 5th window with samples 0x0200 -> locked falls with that update.
5. Abort: enable drops after 30 samples -> IDLE next cycle, no gain_update, gain unchanged; re-enable -> full 64 new samples are required before the next update.
6. Gapped valid: mag_valid every 3rd cycle plus a valid pulse in the UPDATE cycle -> exactly one update per 64 counted samples, and the UPDATE-cycle sample is not included in the next window's sum.
